// File: rtl/exec_seq.sv
// exec_seq: fetch/execute/commit sequencer driving the register-file commit strobe,
// with commit-boundary interrupt entry, halt/single-step debug and a sticky fetch watchdog.
module exec_seq #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ack,
  input  logic             ex_done,
  input  logic             intr_req,
  input  logic             intr_en,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             imem_req,
  output logic             ex_start,
  output logic             w_en,
  output logic             intr_take,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    COMMIT,
    HALT,
    FAULT
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [15:0]      wdog_q, wdog_d;
  logic             step_q, step_d;
  logic             first_q, first_d;
  logic             intr_q, intr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      step_q  <= 1'b0;
      first_q <= 1'b0;
      intr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      step_q  <= step_d;
      first_q <= first_d;
      intr_q  <= intr_d;
      cnt_q   <= cnt_d;
    end
  end

  // first_q marks the EXEC cycle right after FETCH; intr_q holds the last EXEC-cycle sample.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wdog_d  = '0;
    cnt_d   = cnt_q;
    first_d = (state_q == FETCH);
    intr_d  = (state_q == EXEC) & intr_req & intr_en;
    case (state_q)
      IDLE: state_d = halt_req ? HALT : FETCH;
      FETCH: begin
        if (imem_ack) begin
          state_d = EXEC;
        end else if (wdog_q == WD_LAST) begin
          state_d = FAULT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      EXEC: begin
        if (ex_done) state_d = COMMIT;
      end
      COMMIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (step_q) begin
          state_d = HALT;
          step_d  = 1'b0;
        end else if (halt_req) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      HALT: begin
        if (step_req) begin
          step_d  = 1'b1;
          state_d = FETCH;
        end else if (!halt_req) begin
          state_d = FETCH;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == FETCH);
    ex_start   = (state_q == EXEC) & first_q;
    w_en       = (state_q == COMMIT);
    intr_take  = (state_q == COMMIT) & intr_q;
    halted     = (state_q == HALT);
    fault      = (state_q == FAULT);
    retire_cnt = cnt_q;
  end

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: directed cycle table, multi-cycle corner sequences and a
// randomized run against a procedural instruction-level reference model.
module tb_exec_seq;

  logic clk;
  logic rst, ack, done, ireq, ien, halt, step;
  logic m_req, m_es, m_we, m_it, m_hl, m_fl;
  logic [3:0] m_cnt;

  logic t_rst, t_ack, t_done, t_ireq, t_ien, t_halt, t_step;
  logic t_req, t_es, t_we, t_it, t_hl, t_fl;
  logic [31:0] t_cnt;

  int n_vec = 0;
  int n_err = 0;

  exec_seq #(.TIMEOUT_CYC(255), .CNT_W(4)) u_main (
    .clk(clk), .reset(rst), .imem_ack(ack), .ex_done(done), .intr_req(ireq),
    .intr_en(ien), .halt_req(halt), .step_req(step), .imem_req(m_req),
    .ex_start(m_es), .w_en(m_we), .intr_take(m_it), .halted(m_hl),
    .fault(m_fl), .retire_cnt(m_cnt)
  );

  exec_seq #(.TIMEOUT_CYC(4), .CNT_W(32)) u_to (
    .clk(clk), .reset(t_rst), .imem_ack(t_ack), .ex_done(t_done), .intr_req(t_ireq),
    .intr_en(t_ien), .halt_req(t_halt), .step_req(t_step), .imem_req(t_req),
    .ex_start(t_es), .w_en(t_we), .intr_take(t_it), .halted(t_hl),
    .fault(t_fl), .retire_cnt(t_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL time_limit: got no finish, expected finish before limit");
    $fatal(1);
  end

  typedef struct packed {
    logic [5:0] in;   // ack, done, ireq, ien, halt, step
    logic [5:0] out;  // req, ex_start, w_en, intr_take, halted, fault
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t mk(input logic [5:0] i, input logic [5:0] o, input logic [3:0] c);
    vec_t v;
    v.in = i; v.out = o; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] mouts();
    return {m_req, m_es, m_we, m_it, m_hl, m_fl};
  endfunction

  task automatic mchk(input string nm, input logic [5:0] o, input logic [3:0] c);
    chk(nm, {22'b0, mouts(), m_cnt}, {22'b0, o, c});
  endtask

  int budget;

  task automatic tick();
    @(posedge clk);
    #1;
    budget--;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {ack, done, ireq, ien, halt, step} = '0;
    @(posedge clk);
    #1;
    mchk("reset_state", 6'b000000, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rnd_in();
    ack  = ($urandom_range(0, 1) == 1);
    done = ($urandom_range(0, 2) == 0);
    ireq = ($urandom_range(0, 1) == 1);
    ien  = ($urandom_range(0, 1) == 1);
    if ($urandom_range(0, 7) == 0) halt = ~halt;
    step = ($urandom_range(0, 3) == 0);
  endtask

  // Walks one instruction at a time: halt wait, fetch, execute, commit.
  task automatic run_model(input int n);
    logic h, st_mode, a, d, it, s, hh, first;
    int wd;
    int unsigned cnt;
    budget = n;
    cnt = 0;
    st_mode = 1'b0;
    do_reset();
    mchk("m_idle", 6'b000000, 4'd0);
    rnd_in();
    h = halt;
    tick();
    while (budget > 0) begin
      if (h) begin
        s = 1'b0; hh = 1'b1;
        while (!s && hh && budget > 0) begin
          mchk("m_halt", 6'b000010, 4'(cnt));
          rnd_in();
          s = step; hh = halt;
          tick();
        end
        st_mode = s;
        if (budget <= 0) return;
      end
      wd = 0; a = 1'b0;
      while (!a && budget > 0) begin
        mchk("m_fetch", 6'b100000, 4'(cnt));
        rnd_in();
        a = ack;
        tick();
        wd++;
        if (!a && wd == 255) begin
          mchk("m_fault", 6'b000001, 4'(cnt));
          return;
        end
      end
      if (budget <= 0) return;
      first = 1'b1; d = 1'b0; it = 1'b0;
      while (!d && budget > 0) begin
        mchk("m_exec", first ? 6'b010000 : 6'b000000, 4'(cnt));
        rnd_in();
        d = done;
        it = ireq & ien;
        tick();
        first = 1'b0;
      end
      if (budget <= 0) return;
      mchk("m_commit", {2'b00, 1'b1, it, 2'b00}, 4'(cnt));
      rnd_in();
      h = st_mode | halt;
      st_mode = 1'b0;
      cnt = (cnt + 1) % 16;
      tick();
    end
  endtask

  initial begin
    int we_at[$];
    int es_n[4];
    rst = 1'b1; {ack, done, ireq, ien, halt, step} = '0;
    t_rst = 1'b1; {t_ack, t_done, t_ireq, t_ien, t_halt, t_step} = '0;

    tbl[0]  = mk(6'b000000, 6'b000000, 4'd0);
    tbl[1]  = mk(6'b100000, 6'b100000, 4'd0);
    tbl[2]  = mk(6'b011100, 6'b010000, 4'd0);
    tbl[3]  = mk(6'b000000, 6'b001100, 4'd0);
    tbl[4]  = mk(6'b100000, 6'b100000, 4'd1);
    tbl[5]  = mk(6'b011000, 6'b010000, 4'd1);
    tbl[6]  = mk(6'b000000, 6'b001000, 4'd1);
    tbl[7]  = mk(6'b100000, 6'b100000, 4'd2);
    tbl[8]  = mk(6'b010100, 6'b010000, 4'd2);
    tbl[9]  = mk(6'b000000, 6'b001000, 4'd2);
    tbl[10] = mk(6'b000000, 6'b100000, 4'd3);
    tbl[11] = mk(6'b000000, 6'b100000, 4'd3);
    tbl[12] = mk(6'b100000, 6'b100000, 4'd3);
    tbl[13] = mk(6'b000010, 6'b010000, 4'd3);
    tbl[14] = mk(6'b001110, 6'b000000, 4'd3);
    tbl[15] = mk(6'b011110, 6'b000000, 4'd3);
    tbl[16] = mk(6'b000010, 6'b001100, 4'd3);
    tbl[17] = mk(6'b000010, 6'b000010, 4'd4);
    tbl[18] = mk(6'b000011, 6'b000010, 4'd4);
    tbl[19] = mk(6'b100010, 6'b100000, 4'd4);
    tbl[20] = mk(6'b010010, 6'b010000, 4'd4);
    tbl[21] = mk(6'b000010, 6'b001000, 4'd4);
    tbl[22] = mk(6'b000011, 6'b000010, 4'd5);
    tbl[23] = mk(6'b100000, 6'b100000, 4'd5);
    tbl[24] = mk(6'b010000, 6'b010000, 4'd5);
    tbl[25] = mk(6'b000000, 6'b001000, 4'd5);
    tbl[26] = mk(6'b000000, 6'b000010, 4'd6);
    tbl[27] = mk(6'b100000, 6'b100000, 4'd6);
    tbl[28] = mk(6'b011000, 6'b010000, 4'd6);
    tbl[29] = mk(6'b000000, 6'b001000, 4'd6);
    tbl[30] = mk(6'b000000, 6'b100000, 4'd7);

    // Directed cycle table, cycle 0 is IDLE right after reset release.
    do_reset();
    for (int i = 0; i < 31; i++) begin
      {ack, done, ireq, ien, halt, step} = tbl[i].in;
      chk($sformatf("tbl_c%0d", i), {22'b0, mouts(), m_cnt}, {22'b0, tbl[i].out, tbl[i].cnt});
      tick();
    end

    // Slow memory and execute: 4-cycle fetch, 3-cycle execute, period 8.
    do_reset();
    tick();
    es_n = '{0, 0, 0, 0};
    for (int k = 0; k < 32; k++) begin
      if (m_we) we_at.push_back(k);
      if (m_es) es_n[k / 8]++;
      ack  = ((k % 8) == 3);
      done = ((k % 8) == 6);
      tick();
    end
    chk("slow_commits", we_at.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < we_at.size()) chk($sformatf("slow_we_cyc%0d", i), we_at[i], 8 * i + 7);
      chk($sformatf("slow_ex_start%0d", i), es_n[i], 1);
    end

    // Zero-wait run with 4-bit counter wrap, then reset while committing.
    do_reset();
    ack = 1'b1; done = 1'b1;
    for (int c = 0; c <= 54; c++) begin
      if (c <= 10) chk($sformatf("zw_we_c%0d", c), m_we, (c > 0 && c % 3 == 0));
      if (c == 10) chk("zw_cnt3", m_cnt, 3);
      if (c == 46) chk("wrap_cnt15", m_cnt, 15);
      if (c == 49) chk("wrap_cnt0", m_cnt, 0);
      if (c == 52) chk("wrap_cnt1", m_cnt, 1);
      if (c < 54) tick();
    end
    chk("rst_commit_pre", m_we, 1);
    rst = 1'b1;
    #1;
    chk("rst_commit_we", m_we, 0);
    chk("rst_commit_cnt", m_cnt, 0);

    // Halt from IDLE, three single steps, then resume.
    do_reset();
    halt = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      mchk($sformatf("step%0d_halted", s), 6'b000010, 4'(s));
      step = 1'b1; ack = 1'b1; done = 1'b1;
      tick();
      step = 1'b0;
      mchk($sformatf("step%0d_fetch", s), 6'b100000, 4'(s));
      tick();
      mchk($sformatf("step%0d_exec", s), 6'b010000, 4'(s));
      tick();
      mchk($sformatf("step%0d_commit", s), 6'b001000, 4'(s));
      tick();
    end
    mchk("step_back_halt", 6'b000010, 4'd3);
    halt = 1'b0;
    tick();
    mchk("resume_fetch", 6'b100000, 4'd3);

    // Fetch watchdog with TIMEOUT_CYC=4.
    @(posedge clk);
    #1;
    t_rst = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_fetch%0d", k), {t_req, t_fl}, 2'b10);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to_fault%0d", k), {t_req, t_es, t_we, t_it, t_hl, t_fl}, 6'b000001);
      tick();
    end
    t_rst = 1'b1;
    #1;
    chk("to_reset_clears", t_fl, 0);
    @(posedge clk);
    #1;
    t_rst = 1'b0;
    tick();
    tick();
    tick();
    t_ack = 1'b1;
    chk("to_late_ack_fetch", {t_req, t_fl}, 2'b10);
    tick();
    t_ack = 1'b0; t_done = 1'b1;
    chk("to_late_ack_exec", {t_es, t_fl}, 2'b10);
    tick();
    chk("to_late_ack_commit", {t_we, t_fl}, 2'b10);

    // Randomized run against the instruction-level model.
    run_model(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
